rtc_timekeeper: RTL and testbench

//  Parametrised 24 h time-of-day counter (hh:mm:ss) with programmable tick rate, run/pause and time load.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/rtc_timekeeper.sv | 144 ++++++++++++++
 tb/tb_rtc_timekeeper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day types, field widths and wrap limits for the RTC.
// Ports: none (package).
package clock_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_LIMIT  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_LIMIT  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_LIMIT = 5'd23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    // 24 h hour to 1..12 view: midnight and noon both show 12.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0)
            return 5'd12;
        else if (h > 5'd12)
            return h - 5'd12;
        else
            return h;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   en    in  count enable; prescaler holds when low
//   clr   in  restart the count from 0 (takes effect on this edge)
//   tick  out high in the cycle the count sits at TICK_DIV-1 while enabled
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign tick   = en && w_wrap;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24 h hh:mm:ss time-of-day counter with programmable tick rate, run/pause,
// range-checked load, single-step minute/hour adjust, 12 h view and hh:mm alarm.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   run                         1 = count, 0 = freeze prescaler and time
//   load, load_hour/min/sec     one-cycle load strobe and time to load
//   inc_min, inc_hour           one-cycle single-step adjust strobes
//   mode_12h                    selects 1..12 view on hour_disp
//   alarm_en, alarm_hour/min    alarm enable and hh:mm compare value
//   sec, min, hour              registered 24 h time
//   hour_disp, pm               combinational display view of hour
//   sec_tick, day_roll          pulses on applied second / midnight wrap
//   alarm_hit, load_err         pulses on alarm match / rejected load
module rtc_timekeeper
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [MIN_W-1:0]  load_min,
    input  logic [SEC_W-1:0]  load_sec,
    input  logic              inc_min,
    input  logic              inc_hour,
    input  logic              mode_12h,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_roll,
    output logic              alarm_hit,
    output logic              load_err
);

    time_t r_time;
    logic  r_sec_tick;
    logic  r_day_roll;
    logic  r_alarm_hit;
    logic  r_load_err;

    logic  w_tick;
    logic  w_load_ok;
    logic  w_day_wrap;
    time_t w_tick_next;
    time_t w_inc_next;

    assign w_load_ok = (load_hour <= HOUR_LIMIT) && (load_min <= MIN_LIMIT) &&
                       (load_sec <= SEC_LIMIT);

    // Only an accepted load restarts the second phase; a rejected one leaves it alone.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (load && w_load_ok),
        .tick  (w_tick)
    );

    // Seconds carry into minutes into hours.
    always_comb begin
        w_tick_next = r_time;
        w_day_wrap  = 1'b0;
        if (r_time.sec == SEC_LIMIT) begin
            w_tick_next.sec = '0;
            if (r_time.min == MIN_LIMIT) begin
                w_tick_next.min = '0;
                if (r_time.hour == HOUR_LIMIT) begin
                    w_tick_next.hour = '0;
                    w_day_wrap       = 1'b1;
                end else begin
                    w_tick_next.hour = r_time.hour + 5'd1;
                end
            end else begin
                w_tick_next.min = r_time.min + 6'd1;
            end
        end else begin
            w_tick_next.sec = r_time.sec + 6'd1;
        end
    end

    // Adjust strobes wrap their own field only; no carry between fields.
    always_comb begin
        w_inc_next = r_time;
        if (inc_min)
            w_inc_next.min = (r_time.min == MIN_LIMIT) ? '0 : r_time.min + 6'd1;
        if (inc_hour)
            w_inc_next.hour = (r_time.hour == HOUR_LIMIT) ? '0 : r_time.hour + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_time      <= '0;
            r_sec_tick  <= 1'b0;
            r_day_roll  <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_day_roll  <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
            if (load) begin
                if (w_load_ok)
                    r_time <= '{hour: load_hour, min: load_min, sec: load_sec};
                else
                    r_load_err <= 1'b1;
            end else if (inc_min || inc_hour) begin
                r_time <= w_inc_next;
            end else if (w_tick) begin
                r_time      <= w_tick_next;
                r_sec_tick  <= 1'b1;
                r_day_roll  <= w_day_wrap;
                // sec==0 after a tick only on a minute boundary, so the alarm
                // fires once per matching minute and never mid-minute.
                r_alarm_hit <= alarm_en && (w_tick_next.sec == '0) &&
                               (w_tick_next.min == alarm_min) &&
                               (w_tick_next.hour == alarm_hour);
            end
        end
    end

    assign sec       = r_time.sec;
    assign min       = r_time.min;
    assign hour      = r_time.hour;
    assign hour_disp = mode_12h ? to_12h(r_time.hour) : r_time.hour;
    assign pm        = (r_time.hour >= 5'd12);
    assign sec_tick  = r_sec_tick;
    assign day_roll  = r_day_roll;
    assign alarm_hit = r_alarm_hit;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
module tb_rtc_timekeeper;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       mode_12h = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       sec_tick;
    logic       day_roll;
    logic       alarm_hit;
    logic       load_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time kept as seconds since midnight, prescaler as a phase.
    int tod = 0;
    int ph = 0;
    int e_tick = 0, e_roll = 0, e_alarm = 0, e_err = 0;

    rtc_timekeeper #(
        .TICK_DIV (TDIV),
        .CNT_W    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .load       (load),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .inc_min    (inc_min),
        .inc_hour   (inc_hour),
        .mode_12h   (mode_12h),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .hour_disp  (hour_disp),
        .pm         (pm),
        .sec_tick   (sec_tick),
        .day_roll   (day_roll),
        .alarm_hit  (alarm_hit),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tick;
        int h, m, s;
        e_tick = 0; e_roll = 0; e_alarm = 0; e_err = 0;
        tick = run && (ph == TDIV - 1);
        if (reset) begin
            tod = 0;
            ph  = 0;
        end else begin
            if (run) ph = (ph + 1) % TDIV;
            if (load) begin
                if (load_hour < 24 && load_min < 60 && load_sec < 60) begin
                    tod = load_hour * 3600 + load_min * 60 + load_sec;
                    ph  = 0;
                end else begin
                    e_err = 1;
                end
            end else if (inc_min || inc_hour) begin
                h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
                if (inc_min)  m = (m + 1) % 60;
                if (inc_hour) h = (h + 1) % 24;
                tod = h * 3600 + m * 60 + s;
            end else if (tick) begin
                tod     = (tod + 1) % 86400;
                e_tick  = 1;
                e_roll  = (tod == 0);
                e_alarm = alarm_en && (tod == alarm_hour * 3600 + alarm_min * 60);
            end
        end
    endtask

    task automatic cycle();
        int h, d;
        model_step();
        @(posedge clk);
        #1;
        load = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        h = tod / 3600;
        d = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        chk("sec",       sec,       tod % 60);
        chk("min",       min,       (tod / 60) % 60);
        chk("hour",      hour,      h);
        chk("hour_disp", hour_disp, d);
        chk("pm",        pm,        (h >= 12));
        chk("sec_tick",  sec_tick,  e_tick);
        chk("day_roll",  day_roll,  e_roll);
        chk("alarm_hit", alarm_hit, e_alarm);
        chk("load_err",  load_err,  e_err);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
        load = 1'b1;
        cycle();
    endtask

    initial begin
        int cnt;
        // Reset state
        reset = 1'b1; run = 1'b1; load = 1'b1; load_hour = 5'd12;
        cycle();
        cycle();
        chk("rst_time", {hour, min, sec}, 0);
        reset = 1'b0;

        // 1. 240 cycles -> 60 ticks, 00:01:00
        cnt = 0;
        for (int i = 0; i < 240; i++) begin
            cycle();
            if (sec_tick) cnt++;
        end
        chk("ticks60", cnt, 60);
        chk("t_0100", {hour, min, sec}, {5'd0, 6'd1, 6'd0});

        // 2. midnight wrap
        do_load(23, 59, 58);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (day_roll) cnt++;
        end
        chk("day_roll_cnt", cnt, 1);
        chk("t_midnight", {hour, min, sec}, 0);

        // 3. rejected loads keep time and phase
        cycle();
        do_load(10, 20, 60);
        cycle();
        do_load(24, 0, 0);
        for (int i = 0; i < 6; i++) cycle();
        do_load(5, 60, 0);

        // 4. alarm enabled then disabled
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
        do_load(7, 29, 59);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (alarm_hit) cnt++;
        end
        chk("alarm_once", cnt, 1);
        alarm_en = 1'b0;
        do_load(7, 29, 59);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (alarm_hit) cnt++;
        end
        chk("alarm_off", cnt, 0);

        // 5. 12 h view
        run = 1'b0; mode_12h = 1'b1;
        do_load(0, 0, 0);   chk("d0",  {hour_disp, pm}, {5'd12, 1'b0});
        do_load(12, 0, 0);  chk("d12", {hour_disp, pm}, {5'd12, 1'b1});
        do_load(13, 0, 0);  chk("d13", {hour_disp, pm}, {5'd1, 1'b1});
        do_load(23, 0, 0);  chk("d23", {hour_disp, pm}, {5'd11, 1'b1});
        inc_hour = 1'b1; inc_min = 1'b1; cycle();
        do_load(0, 59, 30);
        inc_min = 1'b1; cycle();
        mode_12h = 1'b0;

        // 6. mixed events: load beats inc and tick in the tick cycle
        run = 1'b1;
        do_load(3, 4, 5);
        for (int i = 0; i < TDIV - 1; i++) cycle();
        inc_min = 1'b1;
        do_load(8, 9, 10);
        chk("load_wins", {hour, min, sec}, {5'd8, 6'd9, 6'd10});
        reset = 1'b1;
        do_load(12, 0, 0);
        chk("rst_over_load", {hour, min, sec}, 0);
        reset = 1'b0;
        do_load(1, 2, 3);
        run = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("frozen", {hour, min, sec}, {5'd1, 6'd2, 6'd3});

        // Random traffic
        run = 1'b1; alarm_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            run      = ($urandom_range(0, 9) != 0);
            mode_12h = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 79) == 0) begin
                alarm_hour = 5'($urandom_range(0, 23));
                alarm_min  = 6'($urandom_range(0, 59));
            end
            inc_min  = ($urandom_range(0, 24) == 0);
            inc_hour = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 11) == 0) begin
                load = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    load_hour = alarm_hour;
                    load_min  = (alarm_min == 6'd0) ? 6'd59 : alarm_min - 6'd1;
                    load_sec  = 6'($urandom_range(57, 59));
                    if (alarm_min == 6'd0)
                        load_hour = (alarm_hour == 5'd0) ? 5'd23 : alarm_hour - 5'd1;
                end else begin
                    load_hour = 5'($urandom_range(0, 25));
                    load_min  = 6'($urandom_range(0, 61));
                    load_sec  = 6'($urandom_range(55, 61));
                end
            end
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
